// File: rtl/gamepad_pkg.sv
// gamepad_pkg: shared types and constants for the NES-style controller poller.
//   state_t          - poller FSM state encoding (IDLE, LATCH, LOW, HIGH, COMMIT)
//   BTN_A..BTN_RIGHT - bit positions of each button in the pad1/pad2 bytes
//   LFSR_SEED/TAPS   - Galois LFSR constants used when GAMEPAD_LFSR_EN is defined
//   max_u()          - helper for sizing the shared phase counter
package gamepad_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LATCH  = 3'd1;
    localparam state_t LOW    = 3'd2;
    localparam state_t HIGH   = 3'd3;
    localparam state_t COMMIT = 3'd4;

    // Controllers shift buttons out in this order; first sampled bit lands in bit 0.
    localparam logic [2:0] BTN_A      = 3'd0;
    localparam logic [2:0] BTN_B      = 3'd1;
    localparam logic [2:0] BTN_SELECT = 3'd2;
    localparam logic [2:0] BTN_START  = 3'd3;
    localparam logic [2:0] BTN_UP     = 3'd4;
    localparam logic [2:0] BTN_DOWN   = 3'd5;
    localparam logic [2:0] BTN_LEFT   = 3'd6;
    localparam logic [2:0] BTN_RIGHT  = 3'd7;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gamepad_if.sv
// gamepad_if: bundle of the poller's results as seen by the bus adapter.
//   pad1, pad2 - last complete button frames, 1 = pressed
//   random     - pseudo-random byte (00 when the LFSR is not built)
//   pad_valid  - one-cycle pulse when pad1/pad2 update
//   busy       - poller is inside a frame
// master: driven by gamepad_poller; slave: read by the adapter.
interface gamepad_if;

    logic [7:0] pad1;
    logic [7:0] pad2;
    logic [7:0] random;
    logic       pad_valid;
    logic       busy;

    modport master (
        output pad1,
        output pad2,
        output random,
        output pad_valid,
        output busy
    );

    modport slave (
        input pad1,
        input pad2,
        input random,
        input pad_valid,
        input busy
    );

endinterface

// File: rtl/gamepad_sync.sv
// gamepad_sync: two-flop synchroniser for one asynchronous controller data line.
//   clk   - system clock
//   rst_n - asynchronous active-low reset; output resets to 1 (line idle, buttons released)
//   d     - asynchronous input
//   q     - synchronised output
module gamepad_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gamepad_poller.sv
// gamepad_poller: polls two NES-style serial controllers and holds the last full frame.
// Parameters:
//   DIV      - cycles per pad_latch pulse and per pad_clk half-phase (>= 4)
//   POLL_GAP - idle cycles between frames
// Ports:
//   clk                  - system clock, rising edge
//   _MR                  - asynchronous active-low reset
//   pad1_data, pad2_data - asynchronous active-low serial data from the controllers
//   pad_latch            - parallel-load strobe to both controllers
//   pad_clk              - shift clock to both controllers
//   bus                  - gamepad_if master: pad1, pad2, random, pad_valid, busy
// Build option: GAMEPAD_LFSR_EN adds a 16-bit Galois LFSR driving bus.random.
module gamepad_poller
    import gamepad_pkg::*;
#(
    parameter int unsigned DIV      = 8,
    parameter int unsigned POLL_GAP = 1000
) (
    input  logic       clk,
    input  logic       _MR,
    input  logic       pad1_data,
    input  logic       pad2_data,
    output logic       pad_latch,
    output logic       pad_clk,
    gamepad_if.master  bus
);

    // One phase counter shared by every state, wide enough for the longer interval.
    localparam int unsigned          CNT_W    = $clog2(max_u(DIV, POLL_GAP));
    localparam logic [CNT_W-1:0]     DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]     GAP_LAST = CNT_W'(POLL_GAP - 1);

    logic pad1_sync;
    logic pad2_sync;

    gamepad_sync u_sync1 (
        .clk   (clk),
        .rst_n (_MR),
        .d     (pad1_data),
        .q     (pad1_sync)
    );

    gamepad_sync u_sync2 (
        .clk   (clk),
        .rst_n (_MR),
        .d     (pad2_data),
        .q     (pad2_sync)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sr1_q, sr1_d;
    logic [7:0]       sr2_q, sr2_d;
    logic [7:0]       pad1_q, pad2_q;
    logic             valid_q, latch_q, pclk_q, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        sr1_d   = sr1_q;
        sr2_d   = sr2_q;
        case (state_q)
            IDLE: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end
            end
            LATCH: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end
            end
            LOW: begin
                // Sample at the end of the low phase so data has settled through the sync.
                if (cnt_q == DIV_LAST) begin
                    sr1_d[idx_q] = ~pad1_sync;
                    sr2_d[idx_q] = ~pad2_sync;
                    state_d      = HIGH;
                    cnt_d        = '0;
                end
            end
            HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (idx_q == BTN_RIGHT) begin
                        state_d = COMMIT;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = LOW;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sr1_q   <= 8'h00;
            sr2_q   <= 8'h00;
            pad1_q  <= 8'h00;
            pad2_q  <= 8'h00;
            valid_q <= 1'b0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            // Both bytes move together so the adapter never sees a half-updated frame.
            if (state_q == COMMIT) begin
                pad1_q <= sr1_q;
                pad2_q <= sr2_q;
            end
            valid_q <= (state_q == COMMIT);
            // Decoded from next state so these flops line up with state_q.
            latch_q <= (state_d == LATCH);
            pclk_q  <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign pad_latch     = latch_q;
    assign pad_clk       = pclk_q;
    assign bus.pad1      = pad1_q;
    assign bus.pad2      = pad2_q;
    assign bus.pad_valid = valid_q;
    assign bus.busy      = busy_q;

`ifdef GAMEPAD_LFSR_EN
    logic [15:0] lfsr_q;

    // Right-shifting Galois form; a nonzero seed keeps the state nonzero forever.
    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign bus.random = lfsr_q[7:0];
`else
    assign bus.random = 8'h00;
`endif

endmodule

// File: tb/tb_gamepad_poller.sv
// tb_gamepad_poller: directed bench for gamepad_poller with DIV=4, POLL_GAP=20 and a
// behavioural 4021-style shift register standing in for each controller.
module tb_gamepad_poller;

    localparam int unsigned DIV      = 4;
    localparam int unsigned POLL_GAP = 20;
    localparam int          PERIOD   = POLL_GAP + 17 * DIV + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pad1_data, pad2_data, pad_latch, pad_clk;

    gamepad_if bus_if ();

    gamepad_poller #(
        .DIV      (DIV),
        .POLL_GAP (POLL_GAP)
    ) dut (
        .clk       (clk),
        ._MR       (rst_n),
        .pad1_data (pad1_data),
        .pad2_data (pad2_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    // Controller models: active-low buttons, load while latch high, shift on pad_clk rise.
    logic [7:0] pad1_raw = 8'hFF;
    logic [7:0] pad2_raw = 8'hFF;
    logic       pad1_conn = 1'b1;
    logic [7:0] sr1 = 8'hFF;
    logic [7:0] sr2 = 8'hFF;
    logic       pclk_prev = 1'b0;
    int         rises = 0;

    always @(posedge clk) begin
        pclk_prev <= pad_clk;
        if (pad_clk && !pclk_prev) rises <= rises + 1;
        if (pad_latch) begin
            sr1 <= pad1_raw;
            sr2 <= pad2_raw;
        end else if (pad_clk && !pclk_prev) begin
            sr1 <= {1'b1, sr1[7:1]};
            sr2 <= {1'b1, sr2[7:1]};
        end
    end

    assign pad1_data = pad1_conn ? sr1[0] : 1'b1;
    assign pad2_data = sr2[0];

`ifndef GAMEPAD_LFSR_EN
    logic random_seen = 1'b0;
    always @(posedge clk) if (bus_if.random != 8'h00) random_seen <= 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until pad_valid is seen; -1 if the bound expires.
    int first_random;
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) first_random = int'(bus_if.random);
            if (bus_if.pad_valid) begin
                n = i;
                break;
            end
        end
    endtask

    int n, base, found;

    initial begin
        // 1. Reset
        pad1_raw = 8'b1111_0110;   // A + START pressed
        pad2_raw = 8'hFF;
        #23;
        chk("rst_pad1", bus_if.pad1, 8'h00);
        chk("rst_pad2", bus_if.pad2, 8'h00);
        chk("rst_latch", pad_latch, 1'b0);
        chk("rst_clk", pad_clk, 1'b0);
        chk("rst_valid", bus_if.pad_valid, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
`ifdef GAMEPAD_LFSR_EN
        chk("rst_random", bus_if.random, 8'hE1);
`else
        chk("rst_random", bus_if.random, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 2. First frame after reset
        wait_valid(n);
        chk("t2_latency", n, PERIOD);
`ifdef GAMEPAD_LFSR_EN
        chk("t2_random_step", first_random, 8'h70);
`endif
        chk("t2_pad1", bus_if.pad1, 8'h09);
        chk("t2_pad2", bus_if.pad2, 8'h00);
        chk("t2_busy", bus_if.busy, 1'b0);
        base = rises;

        // 3. Pad1 disconnected, pad2 RIGHT
        pad1_conn = 1'b0;
        pad2_raw  = 8'b0111_1111;
        wait_valid(n);
        chk("t3_period", n, PERIOD);
        chk("t3_pad1", bus_if.pad1, 8'h00);
        chk("t3_pad2", bus_if.pad2, 8'h80);
        chk("t3_clk_rises", rises - base, 8);

        // 4. Pad1 change in the middle of a frame
        pad1_conn = 1'b1;
        pad1_raw  = 8'b1111_1110;  // A
        wait_valid(n);
        chk("t4_pad1_a", bus_if.pad1, 8'h01);
        base  = rises;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rises - base == 4 && pad_clk) begin
                found = 1;
                break;
            end
        end
        chk("t4_found_high3", found, 1);
        pad1_raw = 8'b1110_1111;   // UP
        @(posedge clk);
        #1;
        chk("t4_pad1_hold", bus_if.pad1, 8'h01);
        wait_valid(n);
        chk("t4_pad1_old_frame", bus_if.pad1, 8'h01);
        chk("t4_pad2_old_frame", bus_if.pad2, 8'h80);
        wait_valid(n);
        chk("t4_pad1_new_frame", bus_if.pad1, 8'h10);

        // 5. Reset during LOW of bit 5
        base  = rises;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rises - base == 5 && !pad_clk && bus_if.busy) begin
                found = 1;
                break;
            end
        end
        chk("t5_found_low5", found, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_clk", pad_clk, 1'b0);
        chk("t5_latch", pad_latch, 1'b0);
        chk("t5_pad1", bus_if.pad1, 8'h00);
        chk("t5_busy", bus_if.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(n);
        chk("t5_restart", n, PERIOD);
        chk("t5_pad1_after", bus_if.pad1, 8'h10);
        chk("t5_pad2_after", bus_if.pad2, 8'h80);

        // 6. Random output
`ifdef GAMEPAD_LFSR_EN
        chk("t6_random_step", first_random, 8'h70);
`else
        repeat (1000) @(posedge clk);
        #1;
        chk("t6_random_zero", random_seen, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
